st_indicator: RTL

- Display-side consumer of the top-level state machine's `state` / `state_deep` outputs.
- Turns the current state into user feedback: 8 LEDs plus a 4-digit multiplexed 7-segment display.
- Generates its own blink, walk and scan timing from the system clock.
- Sits between the state machine and the board I/O pins.

---
 rtl/st_indicator_if.sv | 12 +
 rtl/st_indicator.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/st_indicator_if.sv
// rtl/st_indicator_if.sv - state inputs and board-side display outputs of st_indicator
interface st_indicator_if;
  logic [2:0] state;
  logic [2:0] state_deep;
  logic [7:0] led;
  logic [7:0] seg;
  logic [3:0] dig_sel;
  logic       beep;

  modport master (output state, state_deep, input led, seg, dig_sel, beep);
  modport slave  (input state, state_deep, output led, seg, dig_sel, beep);
endinterface

// File: rtl/st_indicator.sv
// rtl/st_indicator.sv - LED and 4-digit 7-seg feedback for the top state machine
// Optional buzzer pulse on state change: define ST_IND_BEEP_EN.
`ifndef CLOCK_FREQ
`define CLOCK_FREQ 50_000_000
`endif
module st_indicator #(
  parameter int CLK_FREQ  = `CLOCK_FREQ,
  parameter int SCAN_DIV  = 1000,
  parameter int FLASH_CYC = CLK_FREQ / 10,
  parameter int BEEP_CYC  = CLK_FREQ / 20
) (
  input  logic          clk_i,
  input  logic          rst_i,
  st_indicator_if.slave bus
);
  localparam int HP_CYC = CLK_FREQ / 4;
  localparam int HP_W   = (HP_CYC > 1) ? $clog2(HP_CYC) : 1;
  localparam int SC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FL_W   = (FLASH_CYC > 1) ? $clog2(FLASH_CYC) : 1;

  localparam logic [2:0] ST_RST   = 3'd0;
  localparam logic [2:0] ST_STOP  = 3'd1;
  localparam logic [2:0] ST_SLEEP = 3'd2;

  function automatic logic [6:0] hex_glyph(input logic [2:0] v);
    case (v)
      3'd0: hex_glyph = 7'h3F;
      3'd1: hex_glyph = 7'h06;
      3'd2: hex_glyph = 7'h5B;
      3'd3: hex_glyph = 7'h4F;
      3'd4: hex_glyph = 7'h66;
      3'd5: hex_glyph = 7'h6D;
      3'd6: hex_glyph = 7'h7D;
      default: hex_glyph = 7'h07;
    endcase
  endfunction

  logic [2:0]      s_q, sp_q;
  logic [1:0]      d_q;
  logic [HP_W-1:0] hp_q, hp_d;
  logic            blink_q, blink_d;
  logic [2:0]      walk_q, walk_d;
  logic [FL_W-1:0] flash_q, flash_d;
  logic [SC_W-1:0] scan_q, scan_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      led_q, led_d, seg_q, seg_d;
  logic [3:0]      dig_q, dig_d;
  logic            beep_d;
  logic            chg, active, hp_wrap, scan_wrap, flash_on;

  wire unused_deep_msb = bus.state_deep[2];

`ifdef ST_IND_BEEP_EN
  localparam int BP_W = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
  logic [BP_W-1:0] bcnt_q, bcnt_d;
  logic            beep_q;
`endif

  always_comb begin
    // s_q vs its delayed copy marks the cycle in which the new state is first decoded
    chg     = (s_q != sp_q);
    active  = (s_q >= 3'd3);
    hp_wrap = (hp_q == HP_W'(HP_CYC - 1));
    hp_d    = hp_wrap ? '0 : hp_q + HP_W'(1);
    blink_d = blink_q ^ hp_wrap;
    walk_d  = walk_q + {2'b00, hp_wrap & blink_q};
    if (chg) begin
      hp_d    = '0;
      blink_d = 1'b0;
    end
    if (chg && s_q == ST_SLEEP) walk_d = '0;

    flash_d = (flash_q != '0) ? flash_q - FL_W'(1) : '0;
    if (chg) flash_d = active ? FL_W'(FLASH_CYC - 1) : '0;
    flash_on = chg ? active : (flash_q != '0);

`ifdef ST_IND_BEEP_EN
    bcnt_d = (bcnt_q != '0) ? bcnt_q - BP_W'(1) : '0;
    if (chg) bcnt_d = BP_W'(BEEP_CYC - 1);
    beep_d = chg | (bcnt_q != '0);
`else
    beep_d = 1'b0;
`endif

    if (flash_on) begin
      led_d = 8'hFF;
    end else begin
      case (s_q)
        ST_RST:   led_d = {8{blink_d}};
        ST_STOP:  led_d = 8'hFF;
        ST_SLEEP: led_d = 8'h01 << walk_d;
        default:  led_d = 8'h01 << s_q;
      endcase
    end

    scan_wrap = (scan_q == SC_W'(SCAN_DIV - 1));
    scan_d    = scan_wrap ? '0 : scan_q + SC_W'(1);
    idx_d     = idx_q - {1'b0, scan_wrap};
    dig_d     = ~(4'b0001 << idx_d);

    case (idx_d)
      2'd3: seg_d = (s_q == ST_STOP) ? 8'h40 : {1'b0, hex_glyph(s_q)};
      2'd2: begin
        case (s_q)
          ST_RST:   seg_d = 8'h50;
          ST_STOP:  seg_d = 8'h6D;
          ST_SLEEP: seg_d = 8'h38;
          default:  seg_d = 8'h00;
        endcase
      end
      2'd1:    seg_d = 8'h00;
      default: seg_d = {beep_d, hex_glyph({1'b0, d_q})};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q     <= '0;
      sp_q    <= '0;
      d_q     <= '0;
      hp_q    <= '0;
      blink_q <= 1'b0;
      walk_q  <= '0;
      flash_q <= '0;
      scan_q  <= '0;
      idx_q   <= 2'd3;
      led_q   <= '0;
      seg_q   <= '0;
      dig_q   <= 4'b1111;
    end else begin
      s_q     <= bus.state;
      sp_q    <= s_q;
      d_q     <= bus.state_deep[1:0];
      hp_q    <= hp_d;
      blink_q <= blink_d;
      walk_q  <= walk_d;
      flash_q <= flash_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

`ifdef ST_IND_BEEP_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcnt_q <= '0;
      beep_q <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      beep_q <= beep_d;
    end
  end
  assign bus.beep = beep_q;
`else
  assign bus.beep = 1'b0;
`endif

  assign bus.led     = led_q;
  assign bus.seg     = seg_q;
  assign bus.dig_sel = dig_q;
endmodule
